// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM state encoding,
// requester identities and the grant helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_D_ACC = 2'd1,
      ST_I_ACC = 2'd2
   } arb_state_t;

   localparam logic REQ_D = 1'b0;
   localparam logic REQ_I = 1'b1;

   // Maps a requester onto the access state that serves it.
   function automatic arb_state_t grant_state(input logic req_id);
      return (req_id == REQ_D) ? ST_D_ACC : ST_I_ACC;
   endfunction

endpackage

// File: rtl/access_watchdog.sv
// Outstanding-access cycle counter; flags the cycle in which an access has been
// held for TIMEOUT cycles. TIMEOUT = 0 disables the flag.
module access_watchdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // The count in the current cycle is the number of cycles already spent,
   // so TIMEOUT-1 marks the last permitted cycle.
   assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between instruction fetch and
// data access, with registered memory strobes and an access watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              I_READ,
   input  logic [ADDR_W-1:0] I_ADDR,
   output logic [DATA_W-1:0] I_RDATA,
   output logic              I_BUSYWAIT,
   input  logic              D_READ,
   input  logic              D_WRITE,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [DATA_W-1:0] D_WDATA,
   input  logic [3:0]        D_BYTEEN,
   output logic [DATA_W-1:0] D_RDATA,
   output logic              D_BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic [3:0]        MEM_BYTEEN,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              MEM_BUSYWAIT,
   output logic              PIPE_BUSYWAIT,
   output logic              ERR
);

   arb_state_t        state_q, state_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_byteen_q, mem_byteen_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_ack_q, i_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              err_q, err_d;
   logic              wd_clear;
   logic              wd_expired;

   access_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .CLK    (CLK),
      .RESET  (RESET),
      .clear  (wd_clear),
      .enable (state_q != ST_IDLE),
      .expired(wd_expired)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= ST_IDLE;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_byteen_q <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_byteen_q <= mem_byteen_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         err_q        <= err_d;
      end
   end

   // A side whose ack is high in this cycle is excluded from the grant, so a
   // request still held during its completion cycle is not serviced twice.
   always_comb begin
      state_d      = state_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_byteen_d = mem_byteen_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      err_d        = err_q;
      wd_clear     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if ((D_READ || D_WRITE) && !d_ack_q) begin
               state_d      = grant_state(REQ_D);
               mem_write_d  = D_WRITE;
               mem_read_d   = D_READ && !D_WRITE;
               mem_addr_d   = D_ADDR;
               mem_wdata_d  = D_WDATA;
               mem_byteen_d = D_BYTEEN;
               wd_clear     = 1'b1;
               if (D_READ && D_WRITE) begin
                  err_d = 1'b1;
               end
            end else if (I_READ && !i_ack_q) begin
               state_d     = grant_state(REQ_I);
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = I_ADDR;
               wd_clear    = 1'b1;
            end
         end

         ST_D_ACC, ST_I_ACC: begin
            if (!MEM_BUSYWAIT || wd_expired) begin
               state_d     = ST_IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (state_q == ST_D_ACC) begin
                  d_ack_d = 1'b1;
                  if (MEM_BUSYWAIT) begin
                     d_rdata_d = '0;
                  end else if (mem_read_q) begin
                     d_rdata_d = MEM_RDATA;
                  end
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = MEM_BUSYWAIT ? '0 : MEM_RDATA;
               end
               if (MEM_BUSYWAIT) begin
                  err_d = 1'b1;
               end
            end
         end

         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   // Stalls are withheld while in reset so a frozen pipeline sees no stall.
   assign I_BUSYWAIT    = RESET && I_READ && !i_ack_q;
   assign D_BUSYWAIT    = RESET && (D_READ || D_WRITE) && !d_ack_q;
   assign PIPE_BUSYWAIT = I_BUSYWAIT || D_BUSYWAIT;

   assign MEM_READ   = mem_read_q;
   assign MEM_WRITE  = mem_write_q;
   assign MEM_ADDR   = mem_addr_q;
   assign MEM_WDATA  = mem_wdata_q;
   assign MEM_BYTEEN = mem_byteen_q;
   assign I_RDATA    = i_rdata_q;
   assign D_RDATA    = d_rdata_q;
   assign ERR        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable memory
// model; expected values are hand-computed per scenario.
module tb_mem_port_arbiter;

   logic        CLK;
   logic        RESET;
   logic        I_READ;
   logic [31:0] I_ADDR;
   logic [31:0] I_RDATA;
   logic        I_BUSYWAIT;
   logic        D_READ;
   logic        D_WRITE;
   logic [31:0] D_ADDR;
   logic [31:0] D_WDATA;
   logic [3:0]  D_BYTEEN;
   logic [31:0] D_RDATA;
   logic        D_BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_WDATA;
   logic [3:0]  MEM_BYTEEN;
   logic [31:0] MEM_RDATA;
   logic        MEM_BUSYWAIT;
   logic        PIPE_BUSYWAIT;
   logic        ERR;

   int          tests_run = 0;
   int          tests_failed = 0;

   int          mem_lat;
   int          mem_cnt;
   logic        mem_stuck;
   logic [31:0] mem_data;

   mem_port_arbiter #(
      .DATA_W (32),
      .ADDR_W (32),
      .TIMEOUT(8)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .I_READ       (I_READ),
      .I_ADDR       (I_ADDR),
      .I_RDATA      (I_RDATA),
      .I_BUSYWAIT   (I_BUSYWAIT),
      .D_READ       (D_READ),
      .D_WRITE      (D_WRITE),
      .D_ADDR       (D_ADDR),
      .D_WDATA      (D_WDATA),
      .D_BYTEEN     (D_BYTEEN),
      .D_RDATA      (D_RDATA),
      .D_BUSYWAIT   (D_BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_WRITE    (MEM_WRITE),
      .MEM_ADDR     (MEM_ADDR),
      .MEM_WDATA    (MEM_WDATA),
      .MEM_BYTEEN   (MEM_BYTEEN),
      .MEM_RDATA    (MEM_RDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT),
      .PIPE_BUSYWAIT(PIPE_BUSYWAIT),
      .ERR          (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory stays busy for mem_lat strobe cycles, or forever when stuck.
   always @(posedge CLK) begin
      if (!(MEM_READ || MEM_WRITE)) begin
         mem_cnt <= 0;
      end else begin
         mem_cnt <= mem_cnt + 1;
      end
   end

   assign MEM_BUSYWAIT = mem_stuck || ((MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat));
   assign MEM_RDATA    = mem_data;

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic i_rd, input logic [31:0] i_ad,
                                input logic d_rd, input logic d_wr,
                                input logic [31:0] d_ad, input logic [31:0] d_wd,
                                input logic [3:0] d_be);
      I_READ   = i_rd;
      I_ADDR   = i_ad;
      D_READ   = d_rd;
      D_WRITE  = d_wr;
      D_ADDR   = d_ad;
      D_WDATA  = d_wd;
      D_BYTEEN = d_be;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      int          hi_cnt;
      int          lo_cnt;
      logic [31:0] got;

      mem_cnt   = 0;
      RESET     = 1'b0;
      mem_lat   = 0;
      mem_stuck = 1'b0;
      mem_data  = 32'h0;

      // Reset with both requests active
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      repeat (3) tick();
      checkOutput("rst_mem_read",   32'(MEM_READ), 32'd0);
      checkOutput("rst_mem_write",  32'(MEM_WRITE), 32'd0);
      checkOutput("rst_mem_addr",   MEM_ADDR, 32'd0);
      checkOutput("rst_i_busy",     32'(I_BUSYWAIT), 32'd0);
      checkOutput("rst_d_busy",     32'(D_BUSYWAIT), 32'd0);
      checkOutput("rst_pipe_busy",  32'(PIPE_BUSYWAIT), 32'd0);
      checkOutput("rst_err",        32'(ERR), 32'd0);
      checkOutput("rst_i_rdata",    I_RDATA, 32'd0);
      checkOutput("rst_d_rdata",    D_RDATA, 32'd0);
      RESET = 1'b1;
      tick();
      checkOutput("first_grant_rd", 32'(MEM_READ), 32'd1);
      checkOutput("first_grant_ad", MEM_ADDR, 32'h10);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) tick();

      // Single I fetch with three busy cycles
      mem_lat  = 3;
      mem_data = 32'hDEADBEEF;
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      checkOutput("ifetch_busy_now", 32'(I_BUSYWAIT), 32'd1);
      hi_cnt = 0;
      lo_cnt = 0;
      got    = 32'h0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 0) checkOutput("ifetch_addr", MEM_ADDR, 32'h100);
         if (MEM_READ) hi_cnt++;
         if (!I_BUSYWAIT) begin
            lo_cnt++;
            got = I_RDATA;
         end
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("ifetch_strobe_cycles", 32'(hi_cnt), 32'd4);
      checkOutput("ifetch_busy_low_cycles", 32'(lo_cnt), 32'd1);
      checkOutput("ifetch_rdata", got, 32'hDEADBEEF);
      repeat (2) tick();

      // Simultaneous I fetch and D store: D first, I in the D ack cycle
      mem_lat  = 1;
      mem_data = 32'hCAFEF00D;
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 32'h2000, 32'h12345678, 4'hF);
      tick();
      checkOutput("both_d_write",  32'(MEM_WRITE), 32'd1);
      checkOutput("both_d_noread", 32'(MEM_READ), 32'd0);
      checkOutput("both_d_addr",   MEM_ADDR, 32'h2000);
      checkOutput("both_d_wdata",  MEM_WDATA, 32'h12345678);
      checkOutput("both_d_byteen", 32'(MEM_BYTEEN), 32'hF);
      tick();
      checkOutput("both_d_busy",   32'(D_BUSYWAIT), 32'd1);
      tick();
      checkOutput("both_d_done",   32'(D_BUSYWAIT), 32'd0);
      checkOutput("both_i_wait",   32'(I_BUSYWAIT), 32'd1);
      checkOutput("both_pipe_a",   32'(PIPE_BUSYWAIT), 32'd1);
      checkOutput("both_strobe_dn", 32'(MEM_WRITE), 32'd0);
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      checkOutput("both_i_grant",  32'(MEM_READ), 32'd1);
      checkOutput("both_i_addr",   MEM_ADDR, 32'h300);
      checkOutput("both_pipe_b",   32'(PIPE_BUSYWAIT), 32'd1);
      tick();
      checkOutput("both_pipe_c",   32'(PIPE_BUSYWAIT), 32'd1);
      tick();
      checkOutput("both_i_done",   32'(I_BUSYWAIT), 32'd0);
      checkOutput("both_pipe_dn",  32'(PIPE_BUSYWAIT), 32'd0);
      checkOutput("both_i_rdata",  I_RDATA, 32'hCAFEF00D);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) tick();

      // Back-to-back D loads with the request held across completion
      mem_lat  = 0;
      mem_data = 32'h11111111;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      tick();
      checkOutput("b2b_grant1",    32'(MEM_READ), 32'd1);
      checkOutput("b2b_addr1",     MEM_ADDR, 32'h40);
      tick();
      checkOutput("b2b_done1",     32'(D_BUSYWAIT), 32'd0);
      checkOutput("b2b_rdata1",    D_RDATA, 32'h11111111);
      mem_data = 32'h22222222;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
      tick();
      checkOutput("b2b_no_dup",    32'(MEM_READ), 32'd0);
      checkOutput("b2b_busy2",     32'(D_BUSYWAIT), 32'd1);
      tick();
      checkOutput("b2b_grant2",    32'(MEM_READ), 32'd1);
      checkOutput("b2b_addr2",     MEM_ADDR, 32'h44);
      checkOutput("b2b_rdata_hold", D_RDATA, 32'h11111111);
      tick();
      checkOutput("b2b_done2",     32'(D_BUSYWAIT), 32'd0);
      checkOutput("b2b_rdata2",    D_RDATA, 32'h22222222);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) tick();

      // Watchdog abort with memory stuck busy
      checkOutput("wd_err_before", 32'(ERR), 32'd0);
      mem_stuck = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      hi_cnt = 0;
      for (int k = 0; k < 9; k++) begin
         tick();
         if (MEM_READ) hi_cnt++;
      end
      checkOutput("wd_strobe_cycles", 32'(hi_cnt), 32'd8);
      checkOutput("wd_strobe_dn",  32'(MEM_READ), 32'd0);
      checkOutput("wd_d_ack",      32'(D_BUSYWAIT), 32'd0);
      checkOutput("wd_rdata_zero", D_RDATA, 32'd0);
      checkOutput("wd_err_set",    32'(ERR), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      mem_stuck = 1'b0;
      repeat (3) tick();
      checkOutput("wd_err_sticky", 32'(ERR), 32'd1);

      // Asynchronous reset in the middle of a D store
      mem_lat = 5;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 32'hA5A5A5A5, 4'h3);
      tick();
      checkOutput("ar_write_on",   32'(MEM_WRITE), 32'd1);
      #3;
      RESET = 1'b0;
      #1;
      checkOutput("ar_write_off",  32'(MEM_WRITE), 32'd0);
      checkOutput("ar_addr_clr",   MEM_ADDR, 32'd0);
      checkOutput("ar_err_clr",    32'(ERR), 32'd0);
      checkOutput("ar_i_rdata_clr", I_RDATA, 32'd0);
      tick();
      RESET   = 1'b1;
      mem_lat = 0;
      tick();
      checkOutput("ar_regrant",    32'(MEM_WRITE), 32'd1);
      checkOutput("ar_regrant_ad", MEM_ADDR, 32'h500);
      checkOutput("ar_regrant_be", 32'(MEM_BYTEEN), 32'h3);
      tick();
      checkOutput("ar_done",       32'(D_BUSYWAIT), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) tick();

      // Load and store requested together: handled as a store, error raised
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h600, 32'h55, 4'hF);
      tick();
      checkOutput("rw_as_write",   32'(MEM_WRITE), 32'd1);
      checkOutput("rw_no_read",    32'(MEM_READ), 32'd0);
      checkOutput("rw_err",        32'(ERR), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
